// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache refill controller.
// Optional feature macro used by the controller: REFILL_TIMEOUT_EN.
package icache_pkg;

    localparam int BEAT_W     = 64;
    localparam int BEAT_BYTES = BEAT_W / 8;
    localparam int DEFAULT_B  = 64;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        COLLECT,
        STREAM,
        DONE
    } refill_state_t;

    // Clears the byte-offset bits so the address points at the start of its block.
    function automatic logic [31:0] block_align(input logic [31:0] addr,
                                                input int unsigned blk_bytes);
        logic [31:0] w_mask;
        w_mask = blk_bytes[31:0] - 32'd1;
        return addr & ~w_mask;
    endfunction

endpackage

// File: rtl/instr_cache_refill_ctrl_if.sv
// Cache-set / memory handshake bundle for the refill controller.
// The controller drives the master side; the cache set and memory sit on the slave side.
interface instr_cache_refill_ctrl_if;
    import icache_pkg::*;

    logic              CacheMiss;
    logic [31:0]       Addr;
    logic              MemReq;
    logic [31:0]       MemAddr;
    logic              MemAck;
    logic              MemValid;
    logic [BEAT_W-1:0] MemData;
    logic              RepReady;
    logic [BEAT_W-1:0] RepWord;
    logic              Stall;
    logic              RefillError;

    modport master (
        input  CacheMiss, Addr, MemAck, MemValid, MemData,
        output MemReq, MemAddr, RepReady, RepWord, Stall, RefillError
    );

    modport slave (
        output CacheMiss, Addr, MemAck, MemValid, MemData,
        input  MemReq, MemAddr, RepReady, RepWord, Stall, RefillError
    );

endinterface

// File: rtl/refill_buffer.sv
// Beat buffer for one cache block: write-by-index, asynchronous read-by-index.
// Holds data only, so it carries no reset.
module refill_buffer
    import icache_pkg::*;
#(
    parameter int Beats = DEFAULT_B / BEAT_BYTES
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(Beats)-1:0] i_widx,
    input  logic [BEAT_W-1:0]        i_wdata,
    input  logic [$clog2(Beats)-1:0] i_ridx,
    output logic [BEAT_W-1:0]        o_rdata
);

    logic [BEAT_W-1:0] r_mem [Beats];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/instr_cache_refill_ctrl.sv
// Instruction-cache refill controller: requests a block, collects its beats, streams them to the set.
// Optional refill timeout is built only when REFILL_TIMEOUT_EN is defined.
module instr_cache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int B             = DEFAULT_B,
    parameter int TimeoutCycles = 255
) (
    input logic                       clk,
    input logic                       reset,
    instr_cache_refill_ctrl_if.master bus
);

    localparam int              Beats    = B / BEAT_BYTES;
    localparam int              CntW     = $clog2(Beats);
    localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

    if (B < 16 || (B & (B - 1)) != 0 || TimeoutCycles < 1) begin : g_cfg_check
        $error("instr_cache_refill_ctrl: B must be a power of two >= 16 and TimeoutCycles >= 1");
    end

    refill_state_t     r_state;
    logic              r_mem_req;
    logic [31:0]       r_mem_addr;
    logic              r_rep_ready;
    logic              r_refill_error;
    logic [CntW-1:0]   r_beat_cnt;
    logic              w_buf_we;
    logic [BEAT_W-1:0] w_buf_rdata;
    logic              w_tmo_hit;

`ifdef REFILL_TIMEOUT_EN
    localparam int TmoW = $clog2(TimeoutCycles + 1);
    logic [TmoW-1:0] r_tmo_cnt;

    // The counter holds the number of REQ/COLLECT cycles already completed, so
    // the abort lands on the edge that closes the TimeoutCycles-th such cycle.
    assign w_tmo_hit = (r_state inside {REQ, COLLECT}) &&
                       (r_tmo_cnt == TmoW'(TimeoutCycles - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    assign w_buf_we = (r_state == COLLECT) && bus.MemValid;

    // The same counter indexes writes while collecting and reads while streaming.
    refill_buffer #(
        .Beats (Beats)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_widx  (r_beat_cnt),
        .i_wdata (bus.MemData),
        .i_ridx  (r_beat_cnt),
        .o_rdata (w_buf_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_mem_req      <= 1'b0;
            r_mem_addr     <= '0;
            r_rep_ready    <= 1'b0;
            r_refill_error <= 1'b0;
            r_beat_cnt     <= '0;
`ifdef REFILL_TIMEOUT_EN
            r_tmo_cnt      <= '0;
`endif
        end else begin
            r_refill_error <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
            if (r_state inside {REQ, COLLECT}) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
`endif
            unique case (r_state)
                IDLE: begin
                    if (bus.CacheMiss) begin
                        r_mem_addr <= block_align(bus.Addr, B);
                        r_mem_req  <= 1'b1;
                        r_state    <= REQ;
`ifdef REFILL_TIMEOUT_EN
                        r_tmo_cnt  <= '0;
`endif
                    end
                end
                REQ: begin
                    if (w_tmo_hit) begin
                        r_mem_req      <= 1'b0;
                        r_refill_error <= 1'b1;
                        r_beat_cnt     <= '0;
                        r_state        <= IDLE;
                    end else if (bus.MemAck) begin
                        r_mem_req <= 1'b0;
                        r_state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A block completing on the timeout edge is kept, not aborted.
                    if (bus.MemValid && r_beat_cnt == LastBeat) begin
                        r_beat_cnt  <= '0;
                        r_rep_ready <= 1'b1;
                        r_state     <= STREAM;
                    end else if (w_tmo_hit) begin
                        r_refill_error <= 1'b1;
                        r_beat_cnt     <= '0;
                        r_state        <= IDLE;
                    end else if (bus.MemValid) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (r_beat_cnt == LastBeat) begin
                        r_beat_cnt  <= '0;
                        r_rep_ready <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.MemReq      = r_mem_req;
    assign bus.MemAddr     = r_mem_addr;
    assign bus.RepReady    = r_rep_ready;
    assign bus.RepWord     = r_rep_ready ? w_buf_rdata : '0;
    assign bus.RefillError = r_refill_error;

    // The IDLE term follows CacheMiss directly so the pipeline stalls in the miss cycle itself.
    assign bus.Stall = ~reset & ((r_state inside {REQ, COLLECT, STREAM}) ||
                                 (r_state == IDLE && bus.CacheMiss));

endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
// Scoreboard bench for instr_cache_refill_ctrl: beats pushed when driven, popped when streamed.
// A second instance with TimeoutCycles=16 exercises the REFILL_TIMEOUT_EN behaviour.
module tb_instr_cache_refill_ctrl;
    import icache_pkg::*;

`ifdef REFILL_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_cache_refill_ctrl_if bus ();
    instr_cache_refill_ctrl_if bus_t ();

    instr_cache_refill_ctrl #(
        .B             (64),
        .TimeoutCycles (255)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    instr_cache_refill_ctrl #(
        .B             (64),
        .TimeoutCycles (16)
    ) dut_t (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_t)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    int          req_cnt  = 0;
    logic        prev_req = 1'b0;
    int          run_len  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Stream monitor: data order, contiguity, zero word when idle, request counting.
    always @(negedge clk) begin
        if (reset) begin
            run_len  = 0;
            prev_req = 1'b0;
        end else begin
            if (bus.MemReq && !prev_req) req_cnt++;
            prev_req = bus.MemReq;
            if (bus.RepReady) begin
                run_len++;
                check_val("stall_in_stream", bus.Stall, 64'd1);
                if (exp_q.size() == 0) check_val("unexpected_rep", bus.RepReady, 64'd0);
                else check_val("rep_word", bus.RepWord, exp_q.pop_front());
            end else begin
                if (run_len != 0) begin
                    check_val("stream_len", 64'(run_len), 64'd8);
                    run_len = 0;
                end
                check_val("rep_word_zero", bus.RepWord, 64'd0);
            end
        end
    end

    // Called just after a rising edge with the DUT in IDLE; returns just after the edge into IDLE.
    task automatic refill(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [63:0] base, input int gap, input int ack_delay,
                          input bit hold, input logic [31:0] hold_addr);
        int req0;
        bus.CacheMiss = 1'b1;
        bus.Addr      = addr;
        @(negedge clk);
        check_val("stall_idle_miss", bus.Stall, 64'd1);
        check_val("memreq_idle", bus.MemReq, 64'd0);
        @(posedge clk); #1;
        req0 = req_cnt;
        if (!hold) bus.CacheMiss = 1'b0;
        for (int i = 0; i < ack_delay; i++) begin
            bus.MemValid = 1'b1;
            bus.MemData  = 64'hBAD0_0000_0000_0000 | 64'(i);
            @(negedge clk);
            check_val("memreq_wait", bus.MemReq, 64'd1);
            check_val("memaddr_wait", 64'(bus.MemAddr), 64'(exp_addr));
            @(posedge clk); #1;
        end
        bus.MemValid = 1'b0;
        bus.MemAck   = 1'b1;
        @(negedge clk);
        check_val("memreq_ack", bus.MemReq, 64'd1);
        check_val("memaddr_ack", 64'(bus.MemAddr), 64'(exp_addr));
        @(posedge clk); #1;
        bus.MemAck = 1'b0;
        check_val("req_count", 64'(req_cnt), 64'(req0 + 1));
        for (int j = 0; j < 8; j++) begin
            if (j > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.MemValid = 1'b0;
                    @(negedge clk);
                    check_val("stall_gap", bus.Stall, 64'd1);
                    @(posedge clk); #1;
                end
            end
            bus.MemValid = 1'b1;
            bus.MemData  = base + 64'(j);
            exp_q.push_back(base + 64'(j));
            @(negedge clk);
            check_val("memreq_collect", bus.MemReq, 64'd0);
            @(posedge clk); #1;
        end
        bus.MemValid = 1'b0;
        if (hold) bus.Addr = hold_addr;
        @(negedge clk);
        check_val("rep_first", bus.RepReady, 64'd1);
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rep_done", bus.RepReady, 64'd0);
        check_val("stall_done", bus.Stall, 64'd0);
        check_val("memreq_done", bus.MemReq, 64'd0);
        check_val("queue_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.CacheMiss   = 1'b0; bus.Addr     = '0; bus.MemAck   = 1'b0;
        bus.MemValid    = 1'b0; bus.MemData  = '0;
        bus_t.CacheMiss = 1'b0; bus_t.Addr   = '0; bus_t.MemAck = 1'b0;
        bus_t.MemValid  = 1'b0; bus_t.MemData = '0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_memreq", bus.MemReq, 64'd0);
        check_val("rst_memaddr", 64'(bus.MemAddr), 64'd0);
        check_val("rst_repready", bus.RepReady, 64'd0);
        check_val("rst_repword", bus.RepWord, 64'd0);
        check_val("rst_stall", bus.Stall, 64'd0);
        check_val("rst_err", bus.RefillError, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic refill, ack in the second REQ cycle, back-to-back beats.
        refill(32'h0000_1234, 32'h0000_1200, 64'h0123_4567_89AB_CD00, 0, 1, 1'b0, 32'h0);
        // Gapped beats: valid, two idle cycles, valid, ...
        refill(32'h0000_5678, 32'h0000_5640, 64'hFEED_0000_0000_0010, 2, 0, 1'b0, 32'h0);
        // Delayed ack with junk MemValid traffic while waiting.
        refill(32'h8000_00FF, 32'h8000_00C0, 64'h5555_AAAA_0000_0100, 0, 20, 1'b0, 32'h0);

        // Reset in the middle of COLLECT after four beats.
        bus.CacheMiss = 1'b1;
        bus.Addr      = 32'h0000_0300;
        @(posedge clk); #1;
        bus.CacheMiss = 1'b0;
        bus.MemAck    = 1'b1;
        @(posedge clk); #1;
        bus.MemAck = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bus.MemValid = 1'b1;
            bus.MemData  = 64'hDEAD_BEEF_0000_0000 | 64'(j);
            @(posedge clk); #1;
        end
        bus.MemData   = 64'hDEAD_BEEF_0000_0004;
        bus.CacheMiss = 1'b1;
        #2 reset = 1'b1;
        #1;
        check_val("midrst_memreq", bus.MemReq, 64'd0);
        check_val("midrst_memaddr", 64'(bus.MemAddr), 64'd0);
        check_val("midrst_repready", bus.RepReady, 64'd0);
        check_val("midrst_repword", bus.RepWord, 64'd0);
        check_val("midrst_stall", bus.Stall, 64'd0);
        check_val("midrst_err", bus.RefillError, 64'd0);
        bus.MemValid  = 1'b0;
        bus.CacheMiss = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        refill(32'h0000_0040, 32'h0000_0040, 64'h0BAD_F00D_0000_0020, 1, 0, 1'b0, 32'h0);

        // Miss hold-off: miss stays high, address moves during STREAM; one new request afterwards.
        refill(32'h0000_1010, 32'h0000_1000, 64'h1111_2222_0000_0030, 0, 1, 1'b1, 32'h0000_2345);
        refill(32'h0000_2345, 32'h0000_2340, 64'h3333_4444_0000_0040, 0, 1, 1'b0, 32'h0);

        // Timeout probe on the TimeoutCycles=16 instance: ack then only three beats.
        bus_t.CacheMiss = 1'b1;
        bus_t.Addr      = 32'h0000_0A00;
        @(posedge clk); #1;
        bus_t.CacheMiss = 1'b0;
        for (int n = 0; n < 30; n++) begin
            bus_t.MemAck   = (n == 1);
            bus_t.MemValid = (n >= 2 && n <= 4);
            bus_t.MemData  = 64'(n);
            @(negedge clk);
            check_val("tmo_err", bus_t.RefillError, 64'(TmoEn && n == 16));
            check_val("tmo_rep", bus_t.RepReady, 64'd0);
            check_val("tmo_memreq", bus_t.MemReq, 64'(n <= 1));
            check_val("tmo_stall", bus_t.Stall, 64'(!TmoEn || n < 16));
            @(posedge clk); #1;
        end
        bus_t.MemAck   = 1'b0;
        bus_t.MemValid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_cache_refill_ctrl.md
INSTR_CACHE_REFILL_CTRL -- requirements
Module: instr_cache_refill_ctrl

Interface
REQ-001 Parameter B, default 64, cache block size in bytes, power of two, 16 or more.
REQ-002 Parameter TimeoutCycles, default 255, cycles allowed per refill; used only with REFILL_TIMEOUT_EN.
REQ-003 Derived constant Beats = B/8, the number of 64-bit words per block (8 at default).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 CacheMiss  input  1  miss from the instruction cache set.
REQ-007 Addr  input  32  fetch address that caused the miss.
REQ-008 MemReq  output  1  block read request to memory.
REQ-009 MemAddr  output  32  block-aligned request address.
REQ-010 MemAck  input  1  memory accepted the request.
REQ-011 MemValid  input  1  MemData holds a valid beat this cycle.
REQ-012 MemData  input  64  refill beat from memory, lowest address first.
REQ-013 RepReady  output  1  replacement-stream enable to the cache set.
REQ-014 RepWord  output  64  replacement word to the cache set.
REQ-015 Stall  output  1  fetch stall to the pipeline.
REQ-016 RefillError  output  1  one-cycle timeout pulse.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, COLLECT, STREAM and DONE.
REQ-018 IDLE: when CacheMiss=1, latch MemAddr={Addr[31:log2(B)], zeros}, move to REQ; Addr is sampled only in this state.
REQ-019 REQ: MemReq=1 and MemAddr held stable until a cycle with MemAck=1, then move to COLLECT; MemReq=0 in every other state.
REQ-020 COLLECT: each MemValid=1 cycle writes MemData into buffer entry BeatCnt and increments BeatCnt; gaps of any length between beats are tolerated.
REQ-021 On the Beats-th valid beat, BeatCnt SHALL clear and the FSM moves to STREAM.
REQ-022 MemValid outside COLLECT SHALL be ignored.
REQ-023 STREAM: RepReady=1 for exactly Beats consecutive cycles; RepWord=buffer[k] in the k-th STREAM cycle, k from 0.
REQ-024 The controller SHALL never insert a gap in the stream.
REQ-025 DONE: lasts one cycle with RepReady=0 and CacheMiss ignored, so the set can resolve the hit, then the FSM returns to IDLE.
REQ-026 Stall=1 in REQ, COLLECT and STREAM, and in IDLE while CacheMiss=1; Stall=0 otherwise.
REQ-027 Refill latency from MemAck to the first RepReady cycle SHALL be Beats valid beats plus 1 cycle.
REQ-028 A new CacheMiss or Addr change during a refill SHALL have no effect until IDLE.
REQ-029 RepWord SHALL be 0 whenever RepReady=0.

Reset
REQ-030 Asserting reset in any state, including mid-COLLECT or mid-STREAM, SHALL immediately force: FSM=IDLE, MemReq=0, MemAddr=0, RepReady=0, RepWord=0, Stall=0, RefillError=0, BeatCnt=0, timeout counter=0.
REQ-031 Buffer contents after reset are unspecified and SHALL never be observable.

Configuration
REQ-032 With macro REFILL_TIMEOUT_EN defined: a counter clears on entry to REQ and increments every cycle in REQ and COLLECT.
REQ-033 If that counter reaches TimeoutCycles before STREAM is entered, RefillError SHALL pulse 1 for one cycle, MemReq SHALL drop, and the FSM SHALL return to IDLE with BeatCnt cleared.
REQ-034 Without REFILL_TIMEOUT_EN: no counter is built, the RefillError port remains, tied 0, and REQ/COLLECT wait indefinitely.

Structure
REQ-035 Shared package icache_pkg SHALL hold the refill-state enum typedef, the 64-bit beat width constant and the default block size.
REQ-036 The beat buffer SHALL be a separate sub-module, refill_buffer: Beats x 64 write-by-index, read-by-index register array.

Verification
REQ-038 Basic refill: Addr=0x0000_1234, CacheMiss=1, MemAck in the 2nd REQ cycle, 8 back-to-back beats 0x..00 to 0x..07 -> MemAddr=0x0000_1200; RepReady high exactly 8 cycles carrying words 0..7 in order; then DONE; then IDLE.
REQ-039 Gapped beats: 8 beats with MemValid toggling 1,0,0,1 ... -> stream still 8 contiguous cycles, data in order, Stall held 1 throughout.
REQ-040 Delayed ack: MemAck after 20 cycles -> MemReq=1 and MemAddr stable for all 20 cycles, no RepReady before ack.
REQ-041 Reset mid-operation: assert reset after beat 4 of 8, then a new miss at Addr=0x40 -> all outputs 0 immediately, and the next refill completes with correct fresh data and no stale beats.
REQ-042 Miss hold-off: CacheMiss stays 1 and Addr changes during STREAM and DONE -> no second request until IDLE; with CacheMiss still 1 in IDLE, exactly one new request at the new block address.
REQ-043 Timeout (REFILL_TIMEOUT_EN, TimeoutCycles=16): MemAck given, only 3 beats supplied -> RefillError single pulse at the 16th cycle after REQ entry, no RepReady, FSM in IDLE; without the macro, RefillError stays 0.
